// File: rtl/vr_pkg.sv
// Shared types and helpers for the value range gate: the classification
// enum, the operating-mode encodings and the scalar classification rule.
package vr_pkg;

  typedef enum logic [1:0] {
    VR_OK    = 2'd0,
    VR_BELOW = 2'd1,
    VR_ABOVE = 2'd2,
    VR_EXCL  = 2'd3
  } vr_class_e;

  localparam int VR_MODE_DROP  = 32'sd0;
  localparam int VR_MODE_CLAMP = 32'sd1;
  localparam int VR_MODE_FLAG  = 32'sd2;

  // Classify a sign-extended sample. The checks are ordered so that an
  // out-of-range value is never reported as excluded.
  function automatic vr_class_e vr_class_of(
    input logic signed [31:0] v,
    input logic signed [31:0] lo,
    input logic signed [31:0] hi,
    input logic               lo_incl,
    input logic               hi_incl,
    input logic               ex_en,
    input logic signed [31:0] ex_lo,
    input logic signed [31:0] ex_hi
  );
    vr_class_e c;
    if ((v < lo) || ((v == lo) && !lo_incl)) begin
      c = VR_BELOW;
    end else if ((v > hi) || ((v == hi) && !hi_incl)) begin
      c = VR_ABOVE;
    end else if (ex_en && (v >= ex_lo) && (v < ex_hi)) begin
      c = VR_EXCL;
    end else begin
      c = VR_OK;
    end
    return c;
  endfunction

endpackage

// File: rtl/vr_classify.sv
// Combinational classifier: maps one signed sample to its range class and
// to the value it would take if it were clamped into the allowed set.
module vr_classify
  import vr_pkg::*;
#(
  parameter int WIDTH   = 32'sd16,
  parameter int LO      = -32'sd10,
  parameter int HI      = 32'sd10,
  parameter bit LO_INCL = 1'b1,
  parameter bit HI_INCL = 1'b1,
  parameter bit EX_EN   = 1'b1,
  parameter int EX_LO   = 32'sd1,
  parameter int EX_HI   = 32'sd2
) (
  input  logic [WIDTH-1:0] in_data,
  output vr_class_e        cls,
  output logic [WIDTH-1:0] clamp_data
);

  // Nearest allowed values at each bound.
  localparam logic signed [31:0] LO_TGT32 = LO + (LO_INCL ? 32'sd0 : 32'sd1);
  localparam logic signed [31:0] HI_TGT32 = HI - (HI_INCL ? 32'sd0 : 32'sd1);

  // EX_HI is outside the half-open window, so it only needs to lie inside
  // [LO:HI] (with bound inclusivity) to be a legal landing point.
  localparam bit EXHI_OK =
    ((EX_HI > LO) || ((EX_HI == LO) && LO_INCL)) &&
    ((EX_HI < HI) || ((EX_HI == HI) && HI_INCL));
  localparam logic signed [31:0] EX_TGT32 = EXHI_OK ? EX_HI : (EX_LO - 32'sd1);

  localparam logic [WIDTH-1:0] LO_TGT = LO_TGT32[WIDTH-1:0];
  localparam logic [WIDTH-1:0] HI_TGT = HI_TGT32[WIDTH-1:0];
  localparam logic [WIDTH-1:0] EX_TGT = EX_TGT32[WIDTH-1:0];

  logic signed [31:0] ext_s;

  assign ext_s = 32'($signed(in_data));

  // Classify the sample and pick the clamp target for its class.
  always_comb begin
    cls = vr_class_of(ext_s, LO, HI, LO_INCL, HI_INCL, EX_EN, EX_LO, EX_HI);
    case (cls)
      VR_BELOW: clamp_data = LO_TGT;
      VR_ABOVE: clamp_data = HI_TGT;
      VR_EXCL:  clamp_data = EX_TGT;
      VR_OK:    clamp_data = in_data;
      default:  clamp_data = in_data;
    endcase
  end

endmodule

// File: rtl/vr_gate_checker.sv
// Protocol assertions for the value range gate output stage and counters.
module vr_gate_checker #(
  parameter int WIDTH = 32'sd16,
  parameter int CNT_W = 32'sd8
) (
  input logic             clk,
  input logic             rst,
  input logic             out_valid,
  input logic             out_ready,
  input logic [WIDTH-1:0] out_data,
  input logic [CNT_W-1:0] viol_cnt,
  input logic             viol_seen,
  input logic             clr
);

  // A stalled output word must stay presented and unchanged.
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

  // A clear always leaves the violation state empty, even against a violator.
  a_clr: assert property (@(posedge clk) disable iff (rst)
    clr |=> ((viol_cnt == '0) && !viol_seen));

endmodule

// File: rtl/value_range_gate.sv
// Streaming range gate: classifies each accepted word, passes, clamps or
// drops it, counts violations and presents results through a one-deep
// registered valid/ready stage.
module value_range_gate
  import vr_pkg::*;
#(
  parameter int WIDTH   = 32'sd16,
  parameter int LO      = -32'sd10,
  parameter int HI      = 32'sd10,
  parameter bit LO_INCL = 1'b1,
  parameter bit HI_INCL = 1'b1,
  parameter bit EX_EN   = 1'b1,
  parameter int EX_LO   = 32'sd1,
  parameter int EX_HI   = 32'sd2,
  parameter int MODE    = 32'sd1,
  parameter int CNT_W   = 32'sd8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_class,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             viol_seen,
  input  logic             clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  vr_class_e        cls_s;
  logic [WIDTH-1:0] clamp_s;
  logic [WIDTH-1:0] load_data_s;
  logic             accept_s;
  logic             viol_s;
  logic             load_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  vr_class_e        out_class_r;
  logic [CNT_W-1:0] viol_cnt_r;
  logic             viol_seen_r;

  vr_classify #(
    .WIDTH  (WIDTH),
    .LO     (LO),
    .HI     (HI),
    .LO_INCL(LO_INCL),
    .HI_INCL(HI_INCL),
    .EX_EN  (EX_EN),
    .EX_LO  (EX_LO),
    .EX_HI  (EX_HI)
  ) u_classify (
    .in_data   (in_data),
    .cls       (cls_s),
    .clamp_data(clamp_s)
  );

  // The stage can take a word whenever it is empty or being drained.
  assign in_ready = !out_valid_r || out_ready;

  // Handshake, drop decision and the value that would be loaded.
  always_comb begin
    accept_s = in_valid && in_ready;
    viol_s   = (cls_s != VR_OK);
    if ((MODE == VR_MODE_DROP) && viol_s) begin
      load_s = 1'b0;
    end else begin
      load_s = accept_s;
    end
    if (MODE == VR_MODE_CLAMP) begin
      load_data_s = clamp_s;
    end else begin
      load_data_s = in_data;
    end
  end

  // One-deep output register; a dropped word still lets a drain complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_class_r <= VR_OK;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= load_data_s;
      out_class_r <= cls_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Saturating violation counter and sticky flag; clear beats a new violation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viol_cnt_r  <= '0;
      viol_seen_r <= 1'b0;
    end else if (clr) begin
      viol_cnt_r  <= '0;
      viol_seen_r <= 1'b0;
    end else if (accept_s && viol_s) begin
      viol_seen_r <= 1'b1;
      if (viol_cnt_r != CNT_MAX) begin
        viol_cnt_r <= viol_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_class = out_class_r;
  assign viol_cnt  = viol_cnt_r;
  assign viol_seen = viol_seen_r;

  vr_gate_checker #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .out_valid(out_valid_r),
    .out_ready(out_ready),
    .out_data (out_data_r),
    .viol_cnt (viol_cnt_r),
    .viol_seen(viol_seen_r),
    .clr      (clr)
  );

endmodule

// File: tb/tb_value_range_gate.sv
// Bench for value_range_gate: four differently configured instances, a
// behavioural range model and a scoreboard drained by a separate monitor.
module tb_value_range_gate;

  typedef struct {
    int lo; int hi; bit lo_incl; bit hi_incl; bit ex_en;
    int ex_lo; int ex_hi; int mode; int cnt_max;
  } cfg_t;

  typedef struct { int k; int data; int cls; } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv[4], ordy[4], clr[4];
  logic [15:0] id[4];
  logic        irdy[4], ov[4], seen[4];
  logic [15:0] od[4];
  logic [1:0]  ocls[4];
  logic [7:0]  vc0, vc1, vc2;
  logic [1:0]  vc3;

  cfg_t cfg[4];
  exp_t sbq[$];
  int   nviol[4];
  bit   rand_rdy[4];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  value_range_gate #(.MODE(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_class(ocls[0]),
    .viol_cnt(vc0), .viol_seen(seen[0]), .clr(clr[0]));

  value_range_gate #(.MODE(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_class(ocls[1]),
    .viol_cnt(vc1), .viol_seen(seen[1]), .clr(clr[1]));

  value_range_gate #(.LO_INCL(1'b0), .HI_INCL(1'b0), .MODE(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_class(ocls[2]),
    .viol_cnt(vc2), .viol_seen(seen[2]), .clr(clr[2]));

  value_range_gate #(.CNT_W(2), .MODE(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(irdy[3]), .in_data(id[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .out_class(ocls[3]),
    .viol_cnt(vc3), .viol_seen(seen[3]), .clr(clr[3]));

  function automatic int get_cnt(input int k);
    if (k == 0) return int'(vc0);
    if (k == 1) return int'(vc1);
    if (k == 2) return int'(vc2);
    return int'(vc3);
  endfunction

  // Reference classification straight from the range rules.
  function automatic int ref_class(input cfg_t c, input int v);
    if (v < c.lo || (v == c.lo && !c.lo_incl)) return 1;
    if (v > c.hi || (v == c.hi && !c.hi_incl)) return 2;
    if (c.ex_en && v >= c.ex_lo && v < c.ex_hi) return 3;
    return 0;
  endfunction

  function automatic int ref_data(input cfg_t c, input int v);
    int cl;
    cl = ref_class(c, v);
    if (c.mode != 1 || cl == 0) return v;
    if (cl == 1) return c.lo_incl ? c.lo : c.lo + 1;
    if (cl == 2) return c.hi_incl ? c.hi : c.hi - 1;
    return (ref_class(c, c.ex_hi) == 0) ? c.ex_hi : c.ex_lo - 1;
  endfunction

  function automatic int exp_cnt(input int k);
    return (nviol[k] > cfg[k].cnt_max) ? cfg[k].cnt_max : nviol[k];
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Record one accepted word in the model and queue its expected output.
  task automatic model_accept(input int k, input int v);
    int cl;
    exp_t e;
    cl = ref_class(cfg[k], v);
    if (clr[k]) nviol[k] = 0;
    else if (cl != 0) nviol[k]++;
    if (!(cfg[k].mode == 0 && cl != 0)) begin
      e.k = k; e.data = ref_data(cfg[k], v); e.cls = cl;
      sbq.push_back(e);
    end
  endtask

  // Present one word to instance k and hold it until it is taken.
  task automatic send(input int k, input int v);
    int  waited;
    bit  done;
    waited = 0;
    done   = 1'b0;
    iv[k]  = 1'b1;
    id[k]  = 16'(v);
    while (!done) begin
      @(negedge clk);
      if (irdy[k]) begin
        model_accept(k, v);
        done = 1'b1;
      end else if (waited >= 100) begin
        total++; bad++;
        $display("FAIL accept_timeout dut%0d: got no in_ready in %0d cycles, required acceptance", k, waited);
        done = 1'b1;
      end
      waited++;
      @(posedge clk); #1;
      if (rand_rdy[k]) ordy[k] = 1'($urandom_range(0, 1));
    end
    iv[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every output transfer is popped and compared against the model.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (ov[k] && ordy[k]) begin
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out dut%0d: got data %0d, required no output", k, int'($signed(od[k])));
          end else begin
            e = sbq.pop_front();
            check($sformatf("out_dut dut%0d", k), k, e.k);
            check($sformatf("out_data dut%0d", k), int'($signed(od[k])), e.data);
            check($sformatf("out_class dut%0d", k), int'(ocls[k]), e.cls);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stream[7] = '{-11, -10, 0, 1, 2, 10, 11};
    int viols[5]  = '{-20, -11, 11, 1, 30};
    int v;

    cfg[0] = '{lo:-10, hi:10, lo_incl:1'b1, hi_incl:1'b1, ex_en:1'b1, ex_lo:1, ex_hi:2, mode:1, cnt_max:255};
    cfg[1] = cfg[0]; cfg[1].mode = 0;
    cfg[2] = cfg[0]; cfg[2].lo_incl = 1'b0; cfg[2].hi_incl = 1'b0;
    cfg[3] = cfg[0]; cfg[3].mode = 2; cfg[3].cnt_max = 3;
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0; id[k] = 16'd0; ordy[k] = 1'b0; clr[k] = 1'b0;
      nviol[k] = 0; rand_rdy[k] = 1'b0;
    end

    // Reset state, sampled while reset is held.
    idle(2);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_valid dut%0d", k), int'(ov[k]), 0);
      check($sformatf("rst_data dut%0d", k), int'(od[k]), 0);
      check($sformatf("rst_class dut%0d", k), int'(ocls[k]), 0);
      check($sformatf("rst_cnt dut%0d", k), get_cnt(k), 0);
      check($sformatf("rst_seen dut%0d", k), int'(seen[k]), 0);
    end
    rst = 1'b0;
    idle(1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("idle_ready dut%0d", k), int'(irdy[k]), 1);
      ordy[k] = 1'b1;
    end

    // Clamp mode on the reference stream.
    foreach (stream[i]) send(0, stream[i]);
    check("mode1_cnt", get_cnt(0), 3);
    check("mode1_seen", int'(seen[0]), 1);

    // Drop mode: a dropped violator leaves the stage empty and ready.
    ordy[1] = 1'b0;
    send(1, stream[0]);
    check("drop_ready", int'(irdy[1]), 1);
    check("drop_valid", int'(ov[1]), 0);
    ordy[1] = 1'b1;
    for (int i = 1; i < 7; i++) send(1, stream[i]);
    check("mode0_cnt", get_cnt(1), 3);

    // Exclusive bounds: -10 -> -9, 10 -> 9, 1 -> 2.
    send(2, -10); send(2, 10); send(2, 1);
    check("excl_bounds_cnt", get_cnt(2), 3);
    idle(2);

    // Backpressure: five stalled cycles with a second word waiting.
    ordy[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 16'd3;
    @(negedge clk);
    check("bp_first_ready", int'(irdy[0]), 1);
    model_accept(0, 3);
    @(posedge clk); #1;
    id[0] = 16'd4;
    repeat (5) begin
      @(negedge clk);
      check("bp_stall_ready", int'(irdy[0]), 0);
      check("bp_stall_valid", int'(ov[0]), 1);
      check("bp_stall_data", int'(od[0]), 3);
      @(posedge clk); #1;
    end
    ordy[0] = 1'b1;
    send(0, 4);

    // Narrow counter saturation in flag mode, then clear against a violator.
    foreach (viols[i]) send(3, viols[i]);
    check("sat_cnt", get_cnt(3), 3);
    check("sat_seen", int'(seen[3]), 1);
    clr[3] = 1'b1;
    send(3, -50);
    clr[3] = 1'b0;
    check("clr_cnt", get_cnt(3), 0);
    check("clr_seen", int'(seen[3]), 0);
    idle(2);

    // Randomised traffic with random consumer stalls.
    for (int k = 0; k < 4; k++) begin
      rand_rdy[k] = 1'b1;
      repeat (40) begin
        if ($urandom_range(0, 7) == 0) v = int'($signed(16'($urandom)));
        else v = int'($urandom_range(0, 30)) - 15;
        send(k, v);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      rand_rdy[k] = 1'b0;
      ordy[k] = 1'b1;
      idle(3);
      check($sformatf("rand_cnt dut%0d", k), get_cnt(k), exp_cnt(k));
      check($sformatf("rand_seen dut%0d", k), int'(seen[k]), (nviol[k] > 0) ? 1 : 0);
      check($sformatf("rand_valid_drained dut%0d", k), int'(ov[k]), 0);
    end
    check("sb_empty", sbq.size(), 0);

    // Asynchronous reset while a word is held.
    ordy[0] = 1'b0;
    send(0, 7);
    check("pre_rst_valid", int'(ov[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", int'(ov[0]), 0);
    check("async_rst_cnt", get_cnt(0), 0);
    check("async_rst_seen", int'(seen[0]), 0);
    sbq.delete();
    for (int k = 0; k < 4; k++) nviol[k] = 0;
    idle(2);
    rst = 1'b0;
    ordy[0] = 1'b1;
    idle(5);
    check("post_rst_valid", int'(ov[0]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
